// File: rtl/countdown_timer.sv
// countdown_timer: loadable N-bit down-counter with one-shot / auto-reload modes.
// Loads a start value, counts down to zero on enabled cycles and pulses
// min_tick on the terminal count. In auto-reload mode it restarts from the
// captured reload value; in one-shot mode it parks in DONE.
// Optional feature macro: COUNTDOWN_PRESCALE_EN (adds a PRESCALE-cycle prescaler
// so that only every PRESCALE-th enabled cycle is a count step).
module countdown_timer #(
   parameter int N        = 8,
   parameter int PRESCALE = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         auto_reload,
   input  logic         en,
   output logic [N-1:0] q,
   output logic         min_tick,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   count_q, count_d;
   logic [N-1:0]   reload_q, reload_d;
   logic           mode_q, mode_d;
   logic           step;

`ifdef COUNTDOWN_PRESCALE_EN
   localparam int            PW      = $clog2(PRESCALE);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] ps_q, ps_d;

   // A count step happens only on the enabled cycle that completes a prescale period.
   assign step = en && (ps_q == PS_LAST);

   // Prescaler advances on enabled RUN cycles and restarts on clr/load.
   always_comb begin
      ps_d = ps_q;
      if (clr || load) begin
         ps_d = '0;
      end else if (state_q == RUN && en) begin
         ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end
`else
   // Without the prescaler every enabled cycle is a count step.
   assign step = en;
`endif

   // Next-state and next-count logic; priority is clr, then load, then counting.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      if (clr) begin
         state_d = IDLE;
         count_d = '0;
      end else if (load) begin
         state_d  = RUN;
         count_d  = load_val;
         reload_d = load_val;
         mode_d   = auto_reload;
      end else if (state_q == RUN && step) begin
         if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end else if (mode_q) begin
            count_d = reload_q;
         end else begin
            state_d = DONE;
         end
      end
   end

   // State, count, reload and mode registers; reset abandons any run at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
      end
   end

   // Terminal count: a step taken at zero while running. Suppressed when the
   // same cycle is overridden by clr or load, so a restart never emits a tick.
   always_comb begin
      min_tick = (state_q == RUN) && step && (count_q == '0) && !clr && !load;
   end

   assign q    = count_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors for countdown_timer (default build, N = 8).
// Stimulus pushes the expected outputs for each driven cycle into a scoreboard
// queue; an independent monitor pops and compares on every falling edge.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic       auto_reload = 1'b0;
   logic       en = 1'b0;
   logic [7:0] q;
   logic       min_tick;
   logic       busy;
   logic       done;

   typedef struct {
      logic [7:0] q;
      logic       mt;
      logic       b;
      logic       d;
      string      name;
   } exp_t;

   exp_t sb[$];
   bit   stim_done = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   countdown_timer #(.N(8), .PRESCALE(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .load        (load),
      .load_val    (load_val),
      .auto_reload (auto_reload),
      .en          (en),
      .q           (q),
      .min_tick    (min_tick),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge and record what the
   // outputs must show during that cycle.
   task automatic cyc(input logic r, input logic c, input logic l,
                      input logic [7:0] lv, input logic ar, input logic e,
                      input logic [7:0] eq, input logic emt, input logic eb,
                      input logic ed, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      reset       = r;
      clr         = c;
      load        = l;
      load_val    = lv;
      auto_reload = ar;
      en          = e;
      x.q    = eq;
      x.mt   = emt;
      x.b    = eb;
      x.d    = ed;
      x.name = nm;
      sb.push_back(x);
   endtask

   // Plain enabled/disabled run cycle (no clr/load, reset released).
   task automatic run(input logic e, input logic [7:0] eq, input logic emt,
                      input logic eb, input logic ed, input string nm);
      cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, e, eq, emt, eb, ed, nm);
   endtask

   // Stimulus
   initial begin
      logic [7:0] t3_q [9];
      t3_q = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0};

      // Reset held, then released: IDLE with q = 0 even while en = 1.
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "rst_hold0");
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "rst_hold1");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "idle_en0");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "idle_en1");

      // One-shot from 3.
      cyc(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "os_load");
      run(1'b1, 8'd3, 1'b0, 1'b1, 1'b0, "os_q3");
      run(1'b1, 8'd2, 1'b0, 1'b1, 1'b0, "os_q2");
      run(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, "os_q1");
      run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "os_q0_tick");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "os_done0");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "os_done1");

      // Auto-reload from 2 for 9 enabled cycles.
      cyc(1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "ar_load");
      for (int i = 0; i < 9; i++) begin
         run(1'b1, t3_q[i], (i % 3 == 2), 1'b1, 1'b0, $sformatf("ar_c%0d", i + 1));
      end

      // One-shot from 2 with en toggling (load issued while running at q = 2).
      cyc(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "tog_load");
      run(1'b1, 8'd2, 1'b0, 1'b1, 1'b0, "tog_e1_q2");
      run(1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "tog_e0_q1");
      run(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, "tog_e1_q1");
      run(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "tog_e0_q0");
      run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "tog_e1_tick");
      run(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "tog_done0");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "tog_done1");

      // load_val = 0, auto-reload: a tick on every enabled cycle.
      cyc(1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "z_load");
      run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "z_tick0");
      run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "z_tick1");
      run(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "z_en0");
      run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "z_tick2");
      // Reload while at q = 0 in RUN: no tick in the load cycle.
      cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "z_reload");
      run(1'b1, 8'd5, 1'b0, 1'b1, 1'b0, "rl_q5");

      // clr beats load in the same cycle; then load alone.
      cyc(1'b1, 1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, "clr_load");
      cyc(1'b1, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "clr_idle");
      run(1'b0, 8'd7, 1'b0, 1'b1, 1'b0, "ld7_hold0");
      run(1'b0, 8'd7, 1'b0, 1'b1, 1'b0, "ld7_hold1");
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, "clr_run");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "clr_after");

      // Maximum period: 255 down to 0, then reload to 255 (never wraps early).
      cyc(1'b1, 1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "max_load");
      for (int i = 0; i < 256; i++) begin
         run(1'b1, 8'(255 - i), (i == 255), 1'b1, 1'b0, $sformatf("max_c%0d", i));
      end
      run(1'b0, 8'd255, 1'b0, 1'b1, 1'b0, "max_reload");

      // Asynchronous reset in the middle of a run at q = 5.
      cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd255, 1'b0, 1'b1, 1'b0, "ar5_load");
      run(1'b0, 8'd5, 1'b0, 1'b1, 1'b0, "ar5_q5");
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "async_rst");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "post_rst0");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "post_rst1");

      stim_done = 1'b1;
   end

   // Monitor: compare the DUT outputs against the oldest expectation each cycle.
   initial begin
      int   cycles = 0;
      exp_t e;
      while (!(stim_done && sb.size() == 0)) begin
         @(negedge clk);
         cycles++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || min_tick !== e.mt || busy !== e.b || done !== e.d) begin
               n_fail++;
               $display("[TB] FAIL %s: got q=%0d tick=%0b busy=%0b done=%0b, expected q=%0d tick=%0b busy=%0b done=%0b",
                        e.name, q, min_tick, busy, done, e.q, e.mt, e.b, e.d);
            end else begin
               $display("[TB] ok %s: q=%0d tick=%0b busy=%0b done=%0b",
                        e.name, q, min_tick, busy, done);
            end
         end
         if (cycles > 5000) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL timeout: got %0d cycles, expected at most 5000", cycles);
            break;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable binary down-counter/timer. It is the complement of the team's free-running up-counter: it counts from a loaded value down to zero and flags terminal count with `min_tick`.
- Used for programmable delays, baud/pulse generation and timeouts in the sequential-circuits module set.
- Supports one-shot and auto-reload modes through a small control FSM.

Parameters:
- `N`, default 8: counter width in bits.
- `PRESCALE`, default 4: enabled cycles per count step. Used only when `COUNTDOWN_PRESCALE_EN` is defined; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear to IDLE.
- `load`  in  1  single-cycle load/start strobe.
- `load_val`  in  N  start value captured on `load`.
- `auto_reload`  in  1  mode, captured on `load`: 1 = periodic, 0 = one-shot.
- `en`  in  1  count enable.
- `q`  out  N  current count, registered.
- `min_tick`  out  1  terminal-count pulse.
- `busy`  out  1  high while in state RUN.
- `done`  out  1  high in state DONE (one-shot expired).

Behaviour:
- **Reset** (`reset` = 0, asynchronous):
  - `q` = 0, reload register = 0, mode register = 0, state = IDLE.
  - `min_tick` = 0, `busy` = 0, `done` = 0.
  - Reset taking effect mid-count abandons the run immediately.
- **States:** IDLE, RUN, DONE. `busy` = (state == RUN); `done` = (state == DONE); both decode directly from the state register.
- **Priority each cycle:** `clr` > `load` > count.
- **`clr` = 1:** state ← IDLE, `q` ← 0. The reload and mode registers are unchanged.
- **`load` = 1** (from any state, including RUN):
  - `q` ← `load_val`, reload register ← `load_val`, mode register ← `auto_reload`, state ← RUN.
  - `en` is ignored in the load cycle.
  - `min_tick` is 0 in the load cycle.
- **RUN, count step** (`en` = 1, no `clr`/`load`):
  - If `q` ≠ 0: `q` ← `q` − 1.
  - If `q` == 0 and mode = 1: `q` ← reload register; stay in RUN.
  - If `q` == 0 and mode = 0: state ← DONE; `q` holds 0.
- **RUN, `en` = 0:** `q` and state hold.
- **`min_tick`:** combinational, = (state == RUN) && `en` && (`q` == 0). It is exactly one cycle wide per terminal count.
- **Period:** `load_val` + 1 enabled cycles per `min_tick`. `load_val` = 0 in auto-reload mode gives `min_tick` on every enabled cycle; `load_val` = 0 in one-shot mode gives a single tick on the first enabled cycle.
- **No wrap below zero:** `q` never underflows to 2^N − 1.
- **IDLE and DONE:** `q` holds and `en` is ignored; only `load` leaves these states.
- **Widths:** all arithmetic is N-bit unsigned. The maximum period is 2^N enabled cycles, with `load_val` = 2^N − 1.
- **Latency:** `q` reflects a load or step on the edge after the request. `busy`/`done` change on the same edge as the state.

Optional Feature:
- Macro: `COUNTDOWN_PRESCALE_EN`.
- **Defined:**
  - An internal prescale counter of width ceil(log2(`PRESCALE`)) advances on each `en` cycle in RUN.
  - A count step (and `min_tick` qualification) occurs only on the `en` cycle where the prescaler reaches `PRESCALE` − 1; the prescaler then wraps to 0.
  - The prescaler is cleared by `reset`, `clr` and `load`.
  - Period = (`load_val` + 1) × `PRESCALE` enabled cycles.
- **Not defined:** no prescaler logic is generated; every `en` cycle is a step, as described above.

Test Plan:
1. Reset low during RUN with `q` = 5 → all outputs 0 immediately (asynchronously); after release, state IDLE and `q` holds 0 while `en` = 1.
2. `load_val` = 3, `auto_reload` = 0, `load` pulse, then `en` = 1 continuously:
   - `q` sequence is 3, 2, 1, 0.
   - `min_tick` is high for exactly 1 cycle, when `q` = 0.
   - `done` = 1 and `busy` = 0 thereafter, with `q` holding 0.
3. `load_val` = 2, `auto_reload` = 1, `en` = 1 for 9 cycles:
   - `q` sequence is 2, 1, 0, 2, 1, 0, 2, 1, 0.
   - `min_tick` pulses on cycles 3, 6 and 9; `busy` stays 1.
4. `en` toggled 1, 0, 1, 0… with `load_val` = 2 in one-shot mode → `q` holds on the `en` = 0 cycles; `min_tick` fires only on an `en` = 1 cycle with `q` = 0, after 3 enabled cycles.
5. In RUN with `q` = 4, `load` = 1 and `clr` = 1 in the same cycle → state IDLE, `q` = 0. Next cycle, `load` alone with `load_val` = 7 → `q` = 7 and `busy` = 1.
6. `N` = 4, `load_val` = 15, auto-reload mode → `min_tick` every 16 cycles, with no underflow to 15 except through reload. With `COUNTDOWN_PRESCALE_EN` and `PRESCALE` = 4, `load_val` = 1 → `min_tick` every 8 enabled cycles.
